// File: rtl/wb_skid_reg_pkg.sv
// Shared widths, state encoding and payload type for the EX->WB skid buffer
// and other stage buffers built the same way.
package wb_skid_reg_pkg;

    localparam int unsigned DSIZE = 16;
    localparam int unsigned ISIZE = 16;
    localparam int unsigned RSIZE = 4;

    typedef enum logic [1:0] {
        WbsEmpty = 2'd0,
        WbsOne   = 2'd1,
        WbsFull  = 2'd2
    } wbs_state_e;

    typedef struct packed {
        logic [DSIZE-1:0] aluout;
        logic [ISIZE-1:0] pc;
        logic [RSIZE-1:0] wa;
        logic             wen;
    } wb_payload_t;

endpackage

// File: rtl/wb_skid_reg_if.sv
// Valid/ready write-back bus: master drives the entry, slave drives ready.
interface wb_skid_reg_if;
    import wb_skid_reg_pkg::*;

    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] aluout;
    logic [ISIZE-1:0] pc;
    logic [RSIZE-1:0] wa;
    logic             wen;

    modport master (output valid, aluout, pc, wa, wen, input ready);
    modport slave  (input valid, aluout, pc, wa, wen, output ready);

endinterface

// File: rtl/wb_payload_reg.sv
// Load-enabled write-back payload register with synchronous active-low clear.
module wb_payload_reg
    import wb_skid_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  wb_payload_t d,
    output wb_payload_t q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_skid_reg.sv
// EX->WB pipeline register: 2-entry skid buffer (main + skid) with registered
// in_ready, flush, and a retired-instruction counter.
module wb_skid_reg
    import wb_skid_reg_pkg::*;
#(
    parameter int unsigned CSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    wb_skid_reg_if.slave     in_if,
    wb_skid_reg_if.master    out_if,
    output logic [CSIZE-1:0] retire_cnt
);

    wbs_state_e       state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CSIZE-1:0] retire_cnt_q;

    logic        accept, consume;
    logic        main_load, main_from_skid, skid_load;
    wb_payload_t in_payload, main_d, main_q, skid_q;

    assign in_payload = {in_if.aluout, in_if.pc, in_if.wa, in_if.wen};
    assign accept     = in_if.valid & in_ready_q;
    assign consume    = out_valid_q & out_if.ready;
    assign main_d     = main_from_skid ? skid_q : in_payload;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            WbsEmpty: begin
                if (accept) begin
                    state_d   = WbsOne;
                    main_load = 1'b1;
                end
            end
            WbsOne: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    state_d   = WbsFull;
                    skid_load = 1'b1;
                end else if (consume) begin
                    state_d = WbsEmpty;
                end
            end
            WbsFull: begin
                // in_ready is low here, so only the drain path exists.
                if (consume) begin
                    state_d        = WbsOne;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = WbsEmpty;
        endcase
        // Flush drops held entries and any same-cycle accept; payload is left stale.
        if (flush) begin
            state_d   = WbsEmpty;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= WbsEmpty;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != WbsFull);
            out_valid_q <= (state_d != WbsEmpty);
            if (consume) begin
                retire_cnt_q <= retire_cnt_q + CSIZE'(1);
            end
        end
    end

    wb_payload_reg u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    wb_payload_reg u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_payload),
        .q    (skid_q)
    );

    assign in_if.ready   = in_ready_q;
    assign out_if.valid  = out_valid_q;
    assign out_if.aluout = main_q.aluout;
    assign out_if.pc     = main_q.pc;
    assign out_if.wa     = main_q.wa;
    assign out_if.wen    = main_q.wen;
    assign retire_cnt    = retire_cnt_q;

endmodule
